serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Digit-serial adder/subtractor controller: accepts a WIDTH-bit operand pair,
//  then time-multiplexes one SLICE-bit ripple-carry adder slice over the operands,
//  least-significant digit first, carrying between digits in a register.
//  Trades latency for area; sits between an operand source and a result sink,
//  with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a nonzero multiple of SLICE
//  SLICE   4  adder slice width in bits; N = WIDTH/SLICE digits per operation
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operand pair + controls valid
//  in_ready   out  1        block can accept operands (high only in IDLE, low while rst)
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  cin        in   1        carry-in (ignored when op_sub=1)
//  op_sub     in   1        0: A+B+cin; 1: A-B computed as A+~B+1
//  out_valid  out  1        result valid (high only in DONE)
//  out_ready  in   1        sink accepts result
//  sum        out  WIDTH+1  {carry_out, WIDTH-bit result}; for sub, sum[WIDTH]=1 means no borrow
//  busy       out  1        high in RUN or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, digit counter=0, carry=0, operand/accumulator regs=0,
//    sum=0, out_valid=0, busy=0; in_ready=0 during rst-high cycles, 1 thereafter.
//  - States: IDLE -> RUN on (in_valid & in_ready); RUN -> DONE after N RUN cycles;
//    DONE -> IDLE on out_ready. No other transitions except reset.
//  - Accept edge: latch a; latch b (or ~b if op_sub); carry <= op_sub ? 1 : cin; cnt <= 0.
//  - Each RUN cycle: slice adds low SLICE bits of a_reg, b_reg and carry; a_reg/b_reg
//    shift right by SLICE; slice sum shifts into acc from the MSB end; carry <= slice cout;
//    cnt++. On the cycle cnt==N-1, next state is DONE.
//  - DONE: sum = {carry, acc}, out_valid=1; sum held stable until out_ready sampled high.
//  - Latency: out_valid rises exactly N+1 cycles after the accept edge (N=4 -> 5).
//  - Throughput: one operation per N+2 cycles minimum with out_ready tied high;
//    in_ready is low in RUN/DONE, so no new operands are accepted until IDLE.
//  - Inputs a/b/cin/op_sub are ignored outside the accept edge; changes mid-op have no effect.
//  - rst mid-RUN or mid-DONE: operation aborted, no out_valid pulse, IDLE next cycle.
//  - Width rules: all arithmetic modulo 2^(WIDTH+1); no saturation, no overflow flag.
//  - N=1 (WIDTH==SLICE) legal: one RUN cycle, latency 2.
// STRUCTURE
//  - Package serial_add_pkg: state encoding constants (IDLE/RUN/DONE, 2 bits),
//    function for N and counter width ($clog2(N) floor 1).
//  - One sub-module: add_slice (SLICE-bit ripple carry adder built from per-bit
//    full-adder equations; ports cin, a, b -> cout, s). Controller owns all registers.
// TESTING
//  - WIDTH=16: a=0xFFFF b=0x0001 cin=0 add -> out_valid at accept+5, sum=0x10000.
//  - a=0x0005 b=0x0007 op_sub=1 -> sum=0x0FFFE (borrow, sum[16]=0); 0x0007-0x0005 -> 0x10002.
//  - out_ready low 3 cycles in DONE -> sum/out_valid held, in_ready=0, new in_valid ignored.
//  - rst high on 2nd RUN cycle -> out_valid never rises; in_ready=1 cycle after rst drops.
//  - Back-to-back ops, out_ready=1: 0x1234+0x4321 cin=1 -> 0x05556, then 0x8000+0x8000 -> 0x10000.
//  - WIDTH=4 SLICE=4: a=0xF b=0xF cin=1 -> sum=0x1F at accept+2.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int width, input int slice);
    return width / slice;
  endfunction

  // Digit counter width, never narrower than one bit so N=1 still has a register.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_slice.sv
// SLICE-bit ripple-carry adder built from per-bit full-adder equations.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic             cin,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             cout,
  output logic [SLICE-1:0] s
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE];
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Digit-serial adder/subtractor: one SLICE-bit adder reused LSB digit first,
// carry kept in a register between digits, valid/ready on both sides.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output state_e           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its data until that edge.

  localparam int N  = num_digits(WIDTH, SLICE);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic                   accept;
  logic                   slice_cout;
  logic [SLICE-1:0]       slice_s;
  logic [WIDTH+SLICE-1:0] shift_cat;

  add_slice #(.SLICE(SLICE)) u_slice (
    .cin  (carry_q),
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .cout (slice_cout),
    .s    (slice_s)
  );

  assign accept    = in_valid & in_ready;
  // New digit enters at the MSB end; after N shifts the result is aligned.
  assign shift_cat = {slice_s, acc_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)         state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST)  state_d = ST_DONE;
      ST_DONE: if (out_ready)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    sum       = {carry_q, acc_q};
    dbg_state = state_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (accept) begin
      a_d     = a;
      b_d     = op_sub ? ~b : b;
      carry_d = op_sub ? 1'b1 : cin;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> SLICE;
      b_d     = b_q >> SLICE;
      acc_d   = shift_cat[WIDTH+SLICE-1:SLICE];
      carry_d = slice_cout;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed scoreboard bench for serial_add_sequencer (16/4 and 4/4 instances).
module tb_serial_add_sequencer;
  import serial_add_pkg::*;

  localparam int N16 = 4;
  localparam int N4  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 16/4 ----------------
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, op_sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        out_valid, out_ready = 1'b1, busy;
  logic [16:0] sum;
  state_e      st16;

  serial_add_sequencer #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .busy(busy), .dbg_state(st16)
  );

  // ---------------- DUT 4/4 ----------------
  logic       in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, op_sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       out_valid4, out_ready4 = 1'b1, busy4;
  logic [4:0] sum4;
  state_e     st4;

  serial_add_sequencer #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .op_sub(op_sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .busy(busy4), .dbg_state(st4)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [4:0]  exp4_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a result is consumed in any cycle with out_valid & out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_result16", 32'(sum), 32'h1_FFFF_FFF);
      else                   check("result16", 32'(sum), 32'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) check("unexpected_result4", 32'(sum4), 32'h1_FFFF_FFF);
      else                    check("result4", 32'(sum4), 32'(exp4_q.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  // Presents one operand pair and returns just after its accept edge.
  task automatic issue16(input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub,
                         input logic [16:0] exp, input bit push, output time t_acc);
    int g = 0;
    in_valid = 1'b1; a = ia; b = ib; cin = icin; op_sub = isub;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("accept_wait16", 32'(g < 50), 32'd1);
    @(posedge clk);
    t_acc = $time;
    if (push) exp_q.push_back(exp);
    #1;
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; op_sub = 1'b1;
  endtask

  // Edges from the accept edge to the first edge at which a sink samples out_valid high.
  task automatic measure_latency(input bit wide, output int lat);
    int k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (wide ? out_valid : out_valid4) break;
      k++;
    end
    lat = k + 1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time t0, t1;
    int  lat;
    logic [16:0] held;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_state",     32'(st16),      32'(ST_IDLE));
    check("rst_sum4",      32'(sum4),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Full carry ripple across all digits, plus latency N+1.
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b1, t0);
    measure_latency(1'b1, lat);
    check("latency16", 32'(lat), 32'(N16 + 1));
    idle_cycles(3);

    // Subtraction with and without borrow; cin must be ignored for subtract.
    issue16(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b1, t0);
    idle_cycles(8);
    issue16(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002, 1'b1, t0);
    idle_cycles(8);

    // Back-pressure in DONE: result held, new operands refused.
    out_ready = 1'b0;
    issue16(16'h00FF, 16'h0101, 1'b0, 1'b0, 17'h00200, 1'b1, t0);
    for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
    held = 17'h00200;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; op_sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum",       32'(sum),       32'(held));
      check("hold_in_ready",  32'(in_ready),  32'd0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    idle_cycles(3);
    check("hold_no_extra_op", 32'(busy), 32'd0);

    // Reset during the second RUN cycle aborts the operation.
    issue16(16'h1111, 16'h2222, 1'b0, 1'b0, 17'h0, 1'b0, t0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_state",    32'(st16),     32'(ST_IDLE));
    for (int i = 0; i < 6; i++) begin
      check("abort_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    #1;

    // Back-to-back operations with out_ready tied high: one op per N+2 cycles.
    issue16(16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b1, t0);
    issue16(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1, t1);
    check("throughput16", 32'((t1 - t0) / 10), 32'(N16 + 2));
    idle_cycles(8);

    // Single-digit instance: one RUN cycle, latency 2.
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; op_sub4 = 1'b0;
    @(posedge clk);
    exp4_q.push_back(5'h1F);
    #1 in_valid4 = 1'b0;
    measure_latency(1'b0, lat);
    check("latency4", 32'(lat), 32'(N4 + 1));
    idle_cycles(3);
    in_valid4 = 1'b1; a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; op_sub4 = 1'b1;
    @(posedge clk);
    exp4_q.push_back(5'h0E);
    #1 in_valid4 = 1'b0;
    idle_cycles(5);

    check("drain16", 32'(exp_q.size()),  32'd0);
    check("drain4",  32'(exp4_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
